// File: rtl/prbs15_checker.sv
// PRBS15 (x^15+x^14+1) word-parallel checker. It hunts for the sequence, verifies it,
// then runs a flywheel reference while counting bit errors.
`timescale 1ns/1ps

module prbs15_checker #(
    parameter int LOCK_COUNT   = 8,
    parameter int UNLOCK_COUNT = 4,
    parameter int ERRCNT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    dis,
    input  logic [14:0]             din,
    input  logic                    din_valid,
    input  logic                    clr_err,
    output logic                    locked,
    output logic                    err_word,
    output logic [3:0]              err_bits,
    output logic [ERRCNT_WIDTH-1:0] err_cnt
);

    localparam logic [1:0] S_HUNT   = 2'd0;
    localparam logic [1:0] S_VERIFY = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;

    localparam logic [7:0] LOCK_LIM   = 8'(LOCK_COUNT);
    localparam logic [7:0] UNLOCK_LIM = 8'(UNLOCK_COUNT);

    // Next 15-bit word of the stream: 15 single-bit LFSR steps, LSB shifted out first.
    function automatic logic [14:0] prbs_next(input logic [14:0] x);
        logic [14:0] v;
        v = x;
        for (int i = 0; i < 15; i++) begin
            v = {v[1] ^ v[0], v[14:1]};
        end
        return v;
    endfunction

    logic [1:0]  rst_sync;
    logic        rst_n;
    logic [1:0]  state, state_n;
    logic [14:0] exp, exp_n;
    logic [7:0]  good_run, good_run_n, good_inc;
    logic [7:0]  bad_run, bad_run_n, bad_inc;
    logic        err_word_n;
    logic [3:0]  err_bits_n;
    logic [3:0]  add_bits;
    logic [3:0]  pop;
    logic [14:0] diff;
    logic        valid;
    logic [14:0] f_din, f_exp;
    logic [ERRCNT_WIDTH:0]   cnt_sum;
    logic [ERRCNT_WIDTH-1:0] err_cnt_n;

    // NOTE: assertion is asynchronous, release is retimed through two flops so no
    // state flop sees reset removal close to an active edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    assign valid    = !dis && din_valid;
    assign f_din    = prbs_next(din);
    assign f_exp    = prbs_next(exp);
    assign diff     = din ^ exp;
    assign good_inc = good_run + 8'd1;
    assign bad_inc  = bad_run + 8'd1;
    assign locked   = (state == S_LOCKED);

    // NOTE: blocking assignments inside always_comb build combinational logic; every
    // output gets a default first so no latch is inferred on an unassigned path.
    always_comb begin
        pop = 4'd0;
        for (int i = 0; i < 15; i++) begin
            pop = pop + {3'd0, diff[i]};
        end
    end

    always_comb begin
        state_n    = state;
        exp_n      = exp;
        good_run_n = good_run;
        bad_run_n  = bad_run;
        err_word_n = 1'b0;
        err_bits_n = err_bits;
        add_bits   = 4'd0;
        if (valid) begin
            case (state)
                S_HUNT: begin
                    if (din != 15'd0) begin
                        exp_n      = f_din;
                        good_run_n = 8'd0;
                        state_n    = S_VERIFY;
                    end
                end
                S_VERIFY: begin
                    exp_n = f_din;
                    if (din == exp) begin
                        good_run_n = good_inc;
                        if (good_inc == LOCK_LIM) begin
                            state_n   = S_LOCKED;
                            bad_run_n = 8'd0;
                        end
                    end else begin
                        good_run_n = 8'd0;
                        if (din == 15'd0) state_n = S_HUNT;
                    end
                end
                S_LOCKED: begin
                    // Flywheel: the reference never reseeds from received data here.
                    exp_n = f_exp;
                    if (din == exp) begin
                        bad_run_n  = 8'd0;
                        err_bits_n = 4'd0;
                    end else begin
                        err_word_n = 1'b1;
                        err_bits_n = pop;
                        add_bits   = pop;
                        bad_run_n  = bad_inc;
                        if (bad_inc == UNLOCK_LIM) begin
                            state_n    = S_HUNT;
                            good_run_n = 8'd0;
                            bad_run_n  = 8'd0;
                        end
                    end
                end
                default: state_n = S_HUNT;
            endcase
        end
    end

    assign cnt_sum = {1'b0, err_cnt} + (ERRCNT_WIDTH+1)'(add_bits);

    always_comb begin
        if (clr_err)                     err_cnt_n = ERRCNT_WIDTH'(add_bits);
        else if (cnt_sum[ERRCNT_WIDTH])  err_cnt_n = '1;
        else                             err_cnt_n = cnt_sum[ERRCNT_WIDTH-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_HUNT;
            exp      <= 15'd0;
            good_run <= 8'd0;
            bad_run  <= 8'd0;
            err_word <= 1'b0;
            err_bits <= 4'd0;
            err_cnt  <= '0;
        end else begin
            state    <= state_n;
            exp      <= exp_n;
            good_run <= good_run_n;
            bad_run  <= bad_run_n;
            err_word <= err_word_n;
            err_bits <= err_bits_n;
            err_cnt  <= err_cnt_n;
        end
    end

endmodule

// File: tb/tb_prbs15_checker.sv
// Scoreboard bench for prbs15_checker: stimulus queues expected outputs per clock edge,
// a monitor pops and compares them shortly after that edge.
`timescale 1ns/1ps

module tb_prbs15_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dis = 1'b0;
    logic [14:0] din = 15'd0;
    logic        din_valid = 1'b0;
    logic        clr_err = 1'b0;

    logic        locked, err_word;
    logic [3:0]  err_bits;
    logic [15:0] err_cnt;
    logic        locked4, err_word4;
    logic [3:0]  err_bits4;
    logic [3:0]  err_cnt4;

    prbs15_checker dut (
        .clk(clk), .reset(reset), .dis(dis), .din(din), .din_valid(din_valid),
        .clr_err(clr_err), .locked(locked), .err_word(err_word),
        .err_bits(err_bits), .err_cnt(err_cnt)
    );

    prbs15_checker #(.ERRCNT_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .dis(dis), .din(din), .din_valid(din_valid),
        .clr_err(clr_err), .locked(locked4), .err_word(err_word4),
        .err_bits(err_bits4), .err_cnt(err_cnt4)
    );

    always #12.5 clk = ~clk;

    typedef enum int {SEL_LOCKED, SEL_ERR_WORD, SEL_ERR_BITS, SEL_ERR_CNT, SEL_ERR_CNT4} sel_e;
    typedef struct {
        int    cyc;
        sel_e  sel;
        int    value;
        string name;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          mon_act;
    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    logic [14:0] g;

    function automatic logic [14:0] f15(input logic [14:0] x);
        logic [14:0] v;
        v = x;
        for (int i = 0; i < 15; i++) v = {v[1] ^ v[0], v[14:1]};
        return v;
    endfunction

    task automatic check(input string name, input int actual, input int required);
        n_total++;
        if (actual == required) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, required);
    endtask

    task automatic expect_out(input sel_e s, input int v, input string name);
        exp_t e;
        e.cyc   = cyc + 1;
        e.sel   = s;
        e.value = v;
        e.name  = name;
        sb_q.push_back(e);
    endtask

    task automatic drive(input logic [14:0] w, input logic v, input logic d, input logic c);
        @(negedge clk);
        din       = w;
        din_valid = v;
        dis       = d;
        clr_err   = c;
    endtask

    task automatic send_gen(input logic c);
        drive(g, 1'b1, 1'b0, c);
        g = f15(g);
    endtask

    task automatic send_err(input logic [14:0] mask, input logic c);
        drive(g ^ mask, 1'b1, 1'b0, c);
        g = f15(g);
    endtask

    // Monitor: outputs for the word sampled at edge N are compared 1 ns after edge N.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                mon_e = sb_q.pop_front();
                case (mon_e.sel)
                    SEL_LOCKED:   mon_act = int'(locked);
                    SEL_ERR_WORD: mon_act = int'(err_word);
                    SEL_ERR_BITS: mon_act = int'(err_bits);
                    SEL_ERR_CNT:  mon_act = int'(err_cnt);
                    default:      mon_act = int'(err_cnt4);
                endcase
                if (mon_e.cyc != cyc) check({mon_e.name, "_stale"}, mon_e.cyc, cyc);
                else                  check(mon_e.name, mon_act, mon_e.value);
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        g = 15'h7FFF;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_locked",   int'(locked),   0);
        check("reset_err_word", int'(err_word), 0);
        check("reset_err_bits", int'(err_bits), 0);
        check("reset_err_cnt",  int'(err_cnt),  0);
        reset = 1'b1;
        repeat (3) drive(15'd0, 1'b0, 1'b0, 1'b0);

        // Acquisition from the 7FFF seed: lock on the 9th valid word.
        for (int i = 1; i <= 9; i++) begin
            send_gen(1'b0);
            if (i == 1) expect_out(SEL_LOCKED, 0, "acq_word1_locked");
            if (i == 8) expect_out(SEL_LOCKED, 0, "acq_word8_locked");
            if (i == 9) begin
                expect_out(SEL_LOCKED, 1, "acq_word9_locked");
                expect_out(SEL_ERR_CNT, 0, "acq_err_cnt");
            end
        end

        for (int i = 0; i < 40000; i++) begin
            send_gen(1'b0);
            if (i % 5000 == 4999) begin
                expect_out(SEL_LOCKED, 1, "long_locked");
                expect_out(SEL_ERR_CNT, 0, "long_err_cnt");
                expect_out(SEL_ERR_WORD, 0, "long_err_word");
            end
        end

        // Bits 0 and 7 flipped in one word.
        send_err(15'h0081, 1'b0);
        expect_out(SEL_ERR_WORD, 1, "flip2_err_word");
        expect_out(SEL_ERR_BITS, 2, "flip2_err_bits");
        expect_out(SEL_ERR_CNT, 2, "flip2_err_cnt");
        expect_out(SEL_ERR_CNT4, 2, "flip2_err_cnt4");
        expect_out(SEL_LOCKED, 1, "flip2_locked");
        send_gen(1'b0);
        expect_out(SEL_ERR_WORD, 0, "flip2_next_err_word");
        expect_out(SEL_ERR_BITS, 0, "flip2_next_err_bits");
        expect_out(SEL_ERR_CNT, 2, "flip2_next_err_cnt");

        send_gen(1'b1);
        expect_out(SEL_ERR_CNT, 0, "clr_err_cnt");
        expect_out(SEL_ERR_CNT4, 0, "clr_err_cnt4");

        // Four fully inverted words: 15 errors each, lock drops on the 4th.
        for (int k = 1; k <= 4; k++) begin
            send_err(15'h7FFF, 1'b0);
            expect_out(SEL_ERR_CNT, 15 * k, "inv_err_cnt");
            expect_out(SEL_ERR_CNT4, 15, "inv_err_cnt4_sat");
            expect_out(SEL_ERR_BITS, 15, "inv_err_bits");
            expect_out(SEL_ERR_WORD, 1, "inv_err_word");
            expect_out(SEL_LOCKED, (k < 4) ? 1 : 0, "inv_locked");
        end

        for (int i = 1; i <= 9; i++) begin
            send_gen(1'b0);
            if (i == 8) expect_out(SEL_LOCKED, 0, "relock_word8_locked");
            if (i == 9) begin
                expect_out(SEL_LOCKED, 1, "relock_word9_locked");
                expect_out(SEL_ERR_CNT, 60, "relock_err_cnt");
                expect_out(SEL_ERR_WORD, 0, "relock_err_word");
            end
        end

        // Clear coincident with a 1-bit error loads that word's count.
        send_err(15'h0008, 1'b1);
        expect_out(SEL_ERR_CNT, 1, "clr_hit_err_cnt");
        expect_out(SEL_ERR_CNT4, 1, "clr_hit_err_cnt4");
        expect_out(SEL_ERR_BITS, 1, "clr_hit_err_bits");
        expect_out(SEL_ERR_WORD, 1, "clr_hit_err_word");

        // Gaps and disable pulses with garbage on din: nothing may be sampled.
        for (int i = 0; i < 24; i++) begin
            case (i % 4)
                1: begin
                    drive(15'h1234, 1'b0, 1'b0, 1'b0);
                    expect_out(SEL_ERR_WORD, 0, "gap_err_word");
                end
                2: begin
                    drive(15'h5555, 1'b1, 1'b1, 1'b0);
                    expect_out(SEL_ERR_WORD, 0, "dis_err_word");
                    expect_out(SEL_LOCKED, 1, "dis_locked");
                end
                default: send_gen(1'b0);
            endcase
        end
        expect_out(SEL_ERR_CNT, 1, "gaps_err_cnt");
        expect_out(SEL_ERR_BITS, 0, "gaps_err_bits");

        drive(15'h5555, 1'b1, 1'b1, 1'b1);
        expect_out(SEL_ERR_CNT, 0, "clr_while_dis_err_cnt");
        expect_out(SEL_LOCKED, 1, "clr_while_dis_locked");

        // Error word then asynchronous reset between clock edges.
        send_err(15'h0081, 1'b0);
        expect_out(SEL_ERR_WORD, 1, "pre_reset_err_word");
        expect_out(SEL_ERR_CNT, 2, "pre_reset_err_cnt");
        @(negedge clk);
        din_valid = 1'b0;
        #3 reset = 1'b0;
        #1;
        check("async_reset_locked",   int'(locked),   0);
        check("async_reset_err_word", int'(err_word), 0);
        check("async_reset_err_bits", int'(err_bits), 0);
        check("async_reset_err_cnt",  int'(err_cnt),  0);
        check("async_reset_err_cnt4", int'(err_cnt4), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) drive(15'd0, 1'b0, 1'b0, 1'b0);

        // All-zero words must keep the checker in HUNT.
        for (int i = 0; i < 30; i++) begin
            drive(15'd0, 1'b1, 1'b0, 1'b0);
            if (i == 29) begin
                expect_out(SEL_LOCKED, 0, "zeros_locked");
                expect_out(SEL_ERR_CNT, 0, "zeros_err_cnt");
                expect_out(SEL_ERR_WORD, 0, "zeros_err_word");
            end
        end

        for (int i = 1; i <= 9; i++) begin
            send_gen(1'b0);
            if (i == 8) expect_out(SEL_LOCKED, 0, "post_reset_word8_locked");
            if (i == 9) expect_out(SEL_LOCKED, 1, "post_reset_word9_locked");
        end

        drive(15'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/prbs15_checker.md
PRBS15_CHECKER -- requirements
Module: prbs15_checker

Interface
REQ-001 SHALL provide parameter LOCK_COUNT, default 8: consecutive matching words needed to declare lock (legal 1..255).
REQ-002 SHALL provide parameter UNLOCK_COUNT, default 4: consecutive mismatching words that drop lock (legal 1..255).
REQ-003 SHALL provide parameter ERRCNT_WIDTH, default 16: width of the accumulated bit-error counter (legal 4..32).
REQ-004 clk  input  1  40MHz word clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 dis  input  1  high: checker frozen, all state held.
REQ-007 din  input  15  received PRBS15 word, same bit order as the team's PRBS15 generator output.
REQ-008 din_valid  input  1  din is sampled only on cycles where din_valid=1.
REQ-009 clr_err  input  1  synchronous clear of err_cnt.
REQ-010 locked  output  1  checker is in LOCKED state.
REQ-011 err_word  output  1  one-cycle pulse: the last compared word in LOCKED had at least one bit error.
REQ-012 err_bits  output  4  number of errored bits in the last word compared in LOCKED (0..15).
REQ-013 err_cnt  output  ERRCNT_WIDTH  saturating total of errored bits since reset or clr_err.

Function
REQ-014 Define F(x) as 15 iterations of x <= {x[1]^x[0], x[14:1]} (x^15+x^14+1, LSB out); the word following x in a valid stream SHALL be F(x).
REQ-015 F SHALL be purely combinational inside the block; no multi-cycle computation.
REQ-016 States: HUNT, VERIFY, LOCKED; held in an internal 15-bit register exp and counters good_run and bad_run.
REQ-017 A "valid cycle" is a cycle with dis=0 and din_valid=1; on any other cycle, state, exp, counters and err_cnt SHALL be held, and err_word SHALL be 0.
REQ-018 HUNT, valid cycle, din != 0: exp <= F(din), good_run <= 0, go VERIFY.
REQ-019 HUNT, valid cycle, din == 0 (LFSR lock-up word): stay HUNT, no change.
REQ-020 VERIFY, din == exp: exp <= F(din), good_run += 1; if the incremented value equals LOCK_COUNT, go LOCKED with bad_run <= 0.
REQ-021 VERIFY, din != exp: reseed, exp <= F(din), good_run <= 0, stay VERIFY; if din == 0, go HUNT instead.
REQ-022 LOCKED, din == exp: exp <= F(exp), bad_run <= 0, err_bits <= 0.
REQ-023 LOCKED, din != exp: exp <= F(exp) (flywheel, never reseeded from received data), err_word pulses, err_bits <= popcount(din^exp), err_cnt += that popcount, bad_run += 1.
REQ-024 LOCKED: when the incremented bad_run equals UNLOCK_COUNT, go HUNT; that word's errors SHALL still be counted and flagged.
REQ-025 err_cnt SHALL saturate at all-ones and never wrap.
REQ-026 clr_err=1 SHALL set err_cnt to 0; with a simultaneous counted error, err_cnt SHALL load that word's popcount instead (saturated to width).
REQ-027 clr_err SHALL act even while dis=1 or din_valid=0.
REQ-028 Latency: locked, err_word, err_bits and err_cnt SHALL reflect a valid-cycle word on the rising edge that samples it (visible the following cycle).
REQ-029 No errors SHALL be counted in HUNT or VERIFY; err_bits holds its last value outside LOCKED.

Reset
REQ-030 reset=0 SHALL immediately, without waiting for clk, force state HUNT, exp=0, good_run=0, bad_run=0, locked=0, err_word=0, err_bits=0, err_cnt=0.
REQ-031 Reset assertion mid-stream SHALL abandon any lock; after release the checker re-acquires from HUNT per REQ-018.
REQ-032 Reset release SHALL be synchronised to clk inside the block so the first active edge is clean.

Verification
REQ-033 Generator model seeded 15'h7FFF, continuous valid -> locked=1 after exactly 1+LOCK_COUNT=9 valid words; err_cnt stays 0 over 40000 words.
REQ-034 Locked stream, one word with bits 0 and 7 flipped -> single err_word pulse, err_bits=2, err_cnt=2, lock retained.
REQ-035 Locked stream, 4 consecutive words inverted -> err_cnt=60, locked falls on the 4th word; clean stream re-locks after 9 further words.
REQ-036 din held at 15'h0000 with valid -> stays HUNT, locked=0, err_cnt=0 indefinitely.
REQ-037 ERRCNT_WIDTH=4, locked, two fully inverted words -> err_cnt=15 (saturated); clr_err coincident with a 1-bit error -> err_cnt=1.
REQ-038 Locked stream with din_valid toggling and dis pulses, generator advancing only on valid cycles -> no errors, lock retained; async reset mid-word -> all outputs 0 before the next clk edge.
